// File: rtl/gray_decode.sv
// gray_decode: decodes a sampled Gray-coded counter to binary and checks that
// the samples form a +1 sequence. Once LOCK_CNT consecutive increments have
// been seen the stream is declared locked. While locked, the block reports a
// wrap from all-ones to zero and flags any sequence break, counting breaks in
// a saturating counter.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no reference yet; the next valid sample seeds prev
// ACQ   | counting consecutive +1 samples toward LOCK_CNT
// LOCK  | tracking; a mismatch raises err and drops back to ACQ
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   gray_in   Gray-coded count sample (CBITS)
//   gray_vld  gray_in valid this cycle
//   bin_out   registered binary decode of the last valid sample
//   bin_vld   one-cycle pulse, bin_out updated
//   locked    level, FSM is in LOCK
//   wrap      one-cycle pulse, locked stream wrapped to zero
//   err       one-cycle pulse, sequence break while locked
//   err_cnt   saturating count of err pulses
module gray_decode #(
    parameter int CBITS    = 18,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] gray_in,
    input  logic             gray_vld,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             locked,
    output logic             wrap,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic [1:0]       state;
    logic [CBITS-1:0] prev;
    logic [3:0]       good_cnt;
    logic [CBITS-1:0] dec;
    logic [CBITS-1:0] expected;
    logic             match;
    logic [3:0]       good_nxt;

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        dec = '0;
        for (int i = 0; i < CBITS; i++) begin
            dec[i] = ^(gray_in >> i);
        end
    end

    assign expected = prev + CBITS'(1);
    assign match    = (dec == expected);
    assign good_nxt = good_cnt + 4'd1;
    assign locked   = (state == S_LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            prev     <= '0;
            good_cnt <= 4'd0;
            bin_out  <= '0;
            bin_vld  <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            bin_vld <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;
            if (gray_vld) begin
                bin_out <= dec;
                bin_vld <= 1'b1;
                // Every sample reseeds prev so reacquisition starts from it.
                prev    <= dec;
                case (state)
                    S_IDLE: begin
                        good_cnt <= 4'd0;
                        state    <= S_ACQ;
                    end
                    S_ACQ: begin
                        if (match) begin
                            good_cnt <= good_nxt;
                            if (good_nxt == LOCK_TGT) begin
                                state <= S_LOCK;
                            end
                        end else begin
                            good_cnt <= 4'd0;
                        end
                    end
                    S_LOCK: begin
                        if (match) begin
                            // Only a sample that arrives already locked may wrap.
                            if (dec == '0) begin
                                wrap <= 1'b1;
                            end
                        end else begin
                            err      <= 1'b1;
                            good_cnt <= 4'd0;
                            state    <= S_ACQ;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        good_cnt <= 4'd0;
                        state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/gray_decode.md
GRAY_DECODE -- requirements
Module: gray_decode

Interface
REQ-001 The block SHALL have parameter CBITS, default 18: width of the Gray code word and of the decoded binary value.
REQ-002 The block SHALL have parameter LOCK_CNT, default 4: number of consecutive correct increments needed to declare lock; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port gray_in  input  CBITS  Gray-coded count sample.
REQ-006 The block SHALL have port gray_vld  input  1  gray_in carries a valid sample this cycle.
REQ-007 The block SHALL have port bin_out  output  CBITS  registered binary decode of the last valid sample.
REQ-008 The block SHALL have port bin_vld  output  1  one-cycle pulse; bin_out updated by a valid sample.
REQ-009 The block SHALL have port locked  output  1  level; stream is tracking a +1 sequence.
REQ-010 The block SHALL have port wrap  output  1  one-cycle pulse; locked stream wrapped from all-ones to zero.
REQ-011 The block SHALL have port err  output  1  one-cycle pulse; sequence break detected while locked.
REQ-012 The block SHALL have port err_cnt  output  8  count of err pulses, saturating at 255.

Function
REQ-013 Decode SHALL be b[CBITS-1]=g[CBITS-1], b[i]=b[i+1] XOR g[i] for i<CBITS-1.
REQ-014 Latency SHALL be one cycle: sample with gray_vld=1 at edge k -> bin_out, bin_vld, wrap, err, locked updated at edge k.
REQ-015 When gray_vld=0, bin_out, err_cnt and FSM state SHALL hold, and bin_vld, wrap and err SHALL be 0.
REQ-016 The block SHALL keep register prev (CBITS bits) = decode of the last valid sample; expected = prev+1 modulo 2^CBITS.
REQ-017 The FSM SHALL have states IDLE, ACQ and LOCK; good_cnt SHALL be a 4-bit counter.
REQ-018 In IDLE, a valid sample SHALL load prev, set good_cnt=0 and move to ACQ; no match check is made.
REQ-019 In ACQ, a valid sample equal to expected SHALL increment good_cnt; on reaching LOCK_CNT the FSM SHALL move to LOCK.
REQ-020 In ACQ, a mismatching valid sample SHALL clear good_cnt, stay in ACQ, and raise no err.
REQ-021 In LOCK, a match SHALL stay in LOCK; a mismatch SHALL pulse err, increment err_cnt (saturating), clear good_cnt and move to ACQ.
REQ-022 Every valid sample in any state SHALL load prev with its decode, so reacquisition starts from the new value.
REQ-023 locked SHALL be 1 exactly when the FSM is in LOCK.
REQ-024 wrap SHALL pulse only for a matching sample decoding to 0 while in LOCK before the edge; a sample that completes lock and decodes to 0 SHALL NOT pulse wrap.
REQ-025 err_cnt at 255 SHALL stay 255 on further errors.

Reset
REQ-026 With rst=1 at a rising edge, FSM SHALL go to IDLE and bin_out=0, bin_vld=0, locked=0, wrap=0, err=0, err_cnt=0, prev=0, good_cnt=0.
REQ-027 rst SHALL take priority over gray_vld in the same cycle; that sample SHALL be discarded.
REQ-028 Reset mid-lock SHALL drop locked the next cycle and SHALL NOT raise err.

Verification
REQ-029 The bench SHALL cover: Gray of 0,1,2,3,4 valid on consecutive cycles -> bin_out 0..4 one cycle later; locked=1 after the 5th sample (LOCK_CNT=4); err=0.
REQ-030 The bench SHALL cover: locked, then Gray 0x3FFFE, 0x3FFFF, 0x00000 -> wrap=1 for exactly the cycle after 0x00000; locked stays 1.
REQ-031 The bench SHALL cover: locked at value 10, next sample Gray of 12 -> err=1 for one cycle, err_cnt=1, locked=0; then 13,14,15,16 -> locked=1 again.
REQ-032 The bench SHALL cover: gray_vld toggled 1,0,0,1 with values 5,6 -> no err, bin_vld pulses only after valid cycles, bin_out holds 5 during gaps.
REQ-033 The bench SHALL cover: 300 forced errors (lock, break, relock) -> err_cnt saturates at 255.
REQ-034 The bench SHALL cover: rst=1 with gray_vld=1 while locked -> all outputs 0 next cycle, err_cnt=0, FSM in IDLE, no err pulse.
